// File: rtl/dff_ram_pkg.sv
// rtl/dff_ram_pkg.sv - shared types and constants for dff_ram_param
package dff_ram_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;
    localparam int BYTE_W  = 8;

endpackage

// File: rtl/dff_ram_rd_pipe.sv
// rtl/dff_ram_rd_pipe.sv - RD_LAT-deep read data/valid pipeline with synchronous clear
module dff_ram_rd_pipe #(
    parameter int DATA_W = 72,
    parameter int RD_LAT = 1
) (
    input  logic              clk_i,
    input  logic              clr_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              vld_q [RD_LAT];
    logic [DATA_W-1:0] dat_q [RD_LAT];

    // Data stages only load behind a valid bit, so the last stage holds between pulses.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            for (int k = 0; k < RD_LAT; k++) begin
                vld_q[k] <= 1'b0;
                dat_q[k] <= '0;
            end
        end else begin
            vld_q[0] <= valid_i;
            if (valid_i) begin
                dat_q[0] <= data_i;
            end
            for (int k = 1; k < RD_LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) begin
                    dat_q[k] <= dat_q[k-1];
                end
            end
        end
    end

    assign valid_o = vld_q[RD_LAT-1];
    assign data_o  = dat_q[RD_LAT-1];

endmodule

// File: rtl/dff_ram_param.sv
// rtl/dff_ram_param.sv - flop-based RAM with byte enables, clear sequencer and pipelined reads
module dff_ram_param
    import dff_ram_pkg::*;
#(
    parameter int DATA_W   = 72,
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int RD_LAT   = 1,
    parameter int RDW_MODE = RDW_OLD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     init_req,
    output logic                     init_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W/BYTE_W-1:0] wr_be,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid
);

    localparam int                LANES   = DATA_W / BYTE_W;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [LANES-1:0]  mem_wbe;
    logic [DATA_W-1:0] wr_old, wr_merged, rd_word;
    logic              rd_fire, wr_ok, rd_ok;

    assign wr_ok     = {1'b0, wr_addr} < DEPTH_L;
    assign rd_ok     = {1'b0, rd_addr} < DEPTH_L;
    assign init_busy = (state_q == INIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The clear sequencer borrows the write port: full-width zero write to cnt_q.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        mem_wbe   = wr_be;
        rd_fire   = 1'b0;
        case (state_q)
            INIT: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = '0;
                mem_wbe   = '1;
                if (cnt_q == LAST_A) begin
                    state_d = READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (init_req) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end else begin
                    mem_we  = wr_en && wr_ok;
                    rd_fire = rd_en;
                end
            end
        endcase
    end

    always_comb begin
        wr_old    = mem_q[mem_waddr];
        wr_merged = wr_old;
        for (int i = 0; i < LANES; i++) begin
            if (mem_wbe[i]) begin
                wr_merged[i*BYTE_W +: BYTE_W] = mem_wdata[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (rd_ok) begin
            rd_word = mem_q[rd_addr];
        end
        if (RDW_MODE == RDW_NEW && mem_we && mem_waddr == rd_addr) begin
            rd_word = wr_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[mem_waddr] <= wr_merged;
        end
    end

    dff_ram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk_i   (clk),
        .clr_i   (rst),
        .valid_i (rd_fire),
        .data_i  (rd_word),
        .valid_o (rd_valid),
        .data_o  (rd_data)
    );

endmodule

// File: tb/tb_dff_ram_param.sv
// tb/tb_dff_ram_param.sv - bench for dff_ram_param (RD_LAT=1/old-data and RD_LAT=2/write-through)
module tb_dff_ram_param;

    localparam int DW    = 72;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int LN    = 9;
    localparam logic [DW-1:0] ALL_F = 72'hFF_FFFF_FFFF_FFFF_FFFF;
    localparam logic [DW-1:0] A5    = 72'hA5_A5A5_A5A5_A5A5_A5A5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, init_req, wr_en, rd_en;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;
    logic [LN-1:0] wr_be;
    logic          busy0, busy1, v0, v1;
    logic [DW-1:0] d0, d1;

    dff_ram_param #(.DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(1), .RDW_MODE(0)) u0 (
        .clk(clk), .rst(rst), .init_req(init_req), .init_busy(busy0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d0), .rd_valid(v0));

    dff_ram_param #(.DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(2), .RDW_MODE(1)) u1 (
        .clk(clk), .rst(rst), .init_req(init_req), .init_busy(busy1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d1), .rd_valid(v1));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [LN-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < LN; i++) if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        return r;
    endfunction

    // Transaction-level model: memory array, clear countdown and per-instance read queues.
    typedef struct { int due; logic [DW-1:0] d; } rd_t;
    rd_t           q0[$], q1[$];
    logic [DW-1:0] mdl_mem [DEPTH];
    logic [DW-1:0] oldv, newv, ed0, ed1;
    logic          ev0, ev1, eb;
    int            init_left, cyc;
    bit            armed;

    initial begin
        cyc = 0; armed = 0; init_left = 0;
        ev0 = 0; ev1 = 0; eb = 1; ed0 = '0; ed1 = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                armed = 1; init_left = DEPTH;
                q0.delete(); q1.delete(); ed0 = '0; ed1 = '0;
            end else if (init_left > 0) begin
                mdl_mem[DEPTH-init_left] = '0;
                init_left--;
            end else if (init_req) begin
                init_left = DEPTH;
            end else begin
                if (rd_en) begin
                    oldv = mdl_mem[rd_addr];
                    newv = (wr_en && wr_addr == rd_addr) ? merge(oldv, wr_data, wr_be) : oldv;
                    q0.push_back('{cyc, oldv});
                    q1.push_back('{cyc + 1, newv});
                end
                if (wr_en) mdl_mem[wr_addr] = merge(mdl_mem[wr_addr], wr_data, wr_be);
            end
            ev0 = 0; ev1 = 0;
            if (q0.size() > 0 && q0[0].due == cyc) begin ev0 = 1; ed0 = q0[0].d; void'(q0.pop_front()); end
            if (q1.size() > 0 && q1[0].due == cyc) begin ev1 = 1; ed1 = q1[0].d; void'(q1.pop_front()); end
            eb = (init_left > 0);
        end
    end

    logic [DW-1:0] got0[$], got1[$];
    int            st0[$], st1[$];

    initial forever begin
        @(negedge clk);
        if (armed) begin
            chk("busy0", {71'b0, busy0}, {71'b0, eb});
            chk("busy1", {71'b0, busy1}, {71'b0, eb});
            chk("valid0", {71'b0, v0}, {71'b0, ev0});
            chk("valid1", {71'b0, v1}, {71'b0, ev1});
            chk("data0", d0, ed0);
            chk("data1", d1, ed1);
            if (v0) begin got0.push_back(d0); st0.push_back(cyc); end
            if (v1) begin got1.push_back(d1); st1.push_back(cyc); end
        end
    end

    logic [DW-1:0] ex0[$], ex1[$];

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        init_req = 0; wr_en = 0; rd_en = 0;
        wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d, input logic [LN-1:0] be);
        wr_en = 1; wr_addr = AW'(a); wr_data = d; wr_be = be;
        step();
        wr_en = 0;
    endtask

    task automatic rd_burst(input int a0, input int n);
        for (int i = 0; i < n; i++) begin
            rd_en = 1; rd_addr = AW'(a0 + i);
            step();
        end
        rd_en = 0;
        step(3);
    endtask

    task automatic busy_len(input string nm);
        int n;
        n = 0;
        while (busy1 && n < 20) begin step(); n++; end
        chk(nm, 72'(n), 72'(4));
    endtask

    task automatic check_got(input string nm);
        chk({nm, "_n0"}, 72'(got0.size()), 72'(ex0.size()));
        chk({nm, "_n1"}, 72'(got1.size()), 72'(ex1.size()));
        for (int i = 0; i < ex0.size() && i < got0.size(); i++) chk({nm, "_d0"}, got0[i], ex0[i]);
        for (int i = 0; i < ex1.size() && i < got1.size(); i++) chk({nm, "_d1"}, got1[i], ex1[i]);
        got0.delete(); got1.delete(); st0.delete(); st1.delete();
        ex0.delete(); ex1.delete();
    endtask

    task automatic expect_zeros(input string nm);
        for (int i = 0; i < DEPTH; i++) begin ex0.push_back('0); ex1.push_back('0); end
        rd_burst(0, DEPTH);
        check_got(nm);
    endtask

    int start;

    initial begin
        idle();
        rst = 1;
        step(2);
        chk("rst_valid0", {71'b0, v0}, 72'h0);
        chk("rst_valid1", {71'b0, v1}, 72'h0);
        chk("rst_data1", d1, 72'h0);
        chk("rst_busy0", {71'b0, busy0}, 72'h1);
        rst = 0;
        busy_len("clr_busy_len");
        expect_zeros("clr_read");

        wr(2, ALL_F, 9'h1FF);
        wr(2, 72'h0, 9'h001);
        ex0.push_back(72'hFF_FFFF_FFFF_FFFF_FF00);
        ex1.push_back(72'hFF_FFFF_FFFF_FFFF_FF00);
        rd_burst(2, 1);
        check_got("be_merge");

        wr_en = 1; wr_addr = 1; wr_data = 72'h1234; wr_be = 9'h1FF;
        rd_en = 1; rd_addr = 1;
        step();
        idle();
        step(3);
        ex0.push_back(72'h0);
        ex1.push_back(72'h1234);
        check_got("rdw");

        for (int i = 0; i < DEPTH; i++) wr(i, 72'h10 + 72'(i), 9'h1FF);
        start = cyc;
        rd_burst(0, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            chk("pipe_t0", 72'(st0[i] - start), 72'(1 + i));
            chk("pipe_t1", 72'(st1[i] - start), 72'(2 + i));
        end
        for (int i = 0; i < DEPTH; i++) begin ex0.push_back(72'h10 + 72'(i)); ex1.push_back(72'h10 + 72'(i)); end
        check_got("pipe");

        for (int i = 0; i < DEPTH; i++) wr(i, A5, 9'h1FF);
        init_req = 1; wr_en = 1; wr_addr = 0; wr_data = 72'h1; wr_be = 9'h1FF;
        rd_en = 1; rd_addr = 0;
        step();
        idle();
        busy_len("reinit_busy_len");
        step(2);
        check_got("reinit_drop");
        expect_zeros("reinit_read");

        wr(3, A5, 9'h1FF);
        rd_en = 1; rd_addr = 3;
        step();
        rd_en = 0; rst = 1;
        step();
        rst = 0;
        chk("midrd_data1", d1, 72'h0);
        busy_len("midrd_busy_len");
        ex0.push_back(A5);
        check_got("midrd_drop");
        expect_zeros("midrd_read");

        rst = 1;
        step();
        rst = 0;
        step(2);
        rst = 1;
        step();
        rst = 0;
        busy_len("restart_busy_len");
        expect_zeros("restart_read");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
